// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU/MDU opcodes, forwarding selects, MDU state.
// Build option EX_STAGE_DIV_EN (in ex_mdu/ex_stage_mdu) enables the divider.
package ex_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    localparam logic [2:0] MDU_NONE  = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_MULTU = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_DIVU  = 3'b100;
    localparam logic [2:0] MDU_MFHI  = 3'b101;
    localparam logic [2:0] MDU_MFLO  = 3'b110;

    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_REG_ALT = 2'b11;

    typedef enum logic {MduIdle, MduBusy} mdu_state_e;

    // Replicated into every WB/MEM control bit of a bubble.
    localparam logic BUBBLE_CTRL = 1'b0;

endpackage

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit with HI/LO: one iteration per cycle on operand magnitudes.
// The restoring divider is only built when EX_STAGE_DIV_EN is defined.
module ex_mdu
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              freeze,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              busy_last,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;

    logic              sgn_op, a_neg, b_neg;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W-1:0] mul_hi, mul_lo;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0] it_hi, it_lo, res_hi, res_lo;

`ifdef EX_STAGE_DIV_EN
    logic              div_q, div_d, is_div;
    logic [DATA_W:0]   div_shift;
    logic              div_ok;
    logic [DATA_W-1:0] div_hi, div_lo;

    assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    assign sgn_op = (op == MDU_MULT) || (op == MDU_DIV);

    // Partial remainder always stays below the divisor, so the low DATA_W bits suffice.
    assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
    assign div_ok    = div_shift >= {1'b0, opb_q};
    assign div_hi    = div_ok ? (div_shift[DATA_W-1:0] - opb_q) : div_shift[DATA_W-1:0];
    assign div_lo    = {acc_lo_q[DATA_W-2:0], div_ok};
`else
    assign sgn_op = (op == MDU_MULT);
`endif

    assign a_neg = sgn_op & op_a[DATA_W-1];
    assign b_neg = sgn_op & op_b[DATA_W-1];
    assign mag_a = a_neg ? -op_a : op_a;
    assign mag_b = b_neg ? -op_b : op_b;

    // Shift-add: multiplier shifts out of acc_lo while the product fills in from the top.
    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    assign mul_hi   = mul_sum[DATA_W:1];
    assign mul_lo   = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
    assign prod     = {mul_hi, mul_lo};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;

    always_comb begin
        it_hi  = mul_hi;
        it_lo  = mul_lo;
        res_hi = prod_fix[2*DATA_W-1:DATA_W];
        res_lo = prod_fix[DATA_W-1:0];
`ifdef EX_STAGE_DIV_EN
        if (div_q) begin
            it_hi  = div_hi;
            it_lo  = div_lo;
            res_hi = neg_a_q ? -div_hi : div_hi;
            if (opb_q == '0) begin
                res_lo = '1;
            end else begin
                res_lo = (neg_a_q ^ neg_b_q) ? -div_lo : div_lo;
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef EX_STAGE_DIV_EN
        div_d    = div_q;
`endif
        if (!freeze) begin
            unique case (state_q)
                MduIdle: begin
                    if (start) begin
                        state_d  = MduBusy;
                        cnt_d    = '0;
                        acc_hi_d = '0;
                        acc_lo_d = mag_a;
                        opb_d    = mag_b;
                        neg_a_d  = a_neg;
                        neg_b_d  = b_neg;
`ifdef EX_STAGE_DIV_EN
                        div_d    = is_div;
`endif
                    end
                end
                MduBusy: begin
                    if (abort) begin
                        state_d = MduIdle;
                    end else begin
                        acc_hi_d = it_hi;
                        acc_lo_d = it_lo;
                        if (cnt_q == CNT_LAST) begin
                            hi_d    = res_hi;
                            lo_d    = res_lo;
                            state_d = MduIdle;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = MduIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MduIdle;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef EX_STAGE_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef EX_STAGE_DIV_EN
            div_q    <= div_d;
`endif
        end
    end

    assign busy      = (state_q == MduBusy);
    assign busy_last = busy && (cnt_q == CNT_LAST);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: forwarding, ALU, branch adder, MDU and EX/MEM register.
// Define EX_STAGE_DIV_EN to make DIV/DIVU execute; otherwise they are no-ops.
module ex_stage_mdu
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned WB_CW  = 2,
    parameter int unsigned MEM_CW = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_next_pc,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [REG_AW-1:0] i_tar_reg,
    input  logic [REG_AW-1:0] i_des_reg,
    input  logic [WB_CW-1:0]  i_wb_ctrl,
    input  logic [MEM_CW-1:0] i_mem_ctrl,
    input  logic              i_alu_src,
    input  logic              i_reg_dst,
    input  logic [3:0]        i_alu_op,
    input  logic [2:0]        i_mdu_op,
    input  logic [1:0]        i_fwd_a,
    input  logic [1:0]        i_fwd_b,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_flush,
    input  logic              i_mem_stall,
    output logic              o_stall,
    output logic              o_valid,
    output logic              o_zero,
    output logic [DATA_W-1:0] o_branch_pc,
    output logic [DATA_W-1:0] o_result,
    output logic [DATA_W-1:0] o_rt_data,
    output logic [REG_AW-1:0] o_write_reg,
    output logic [WB_CW-1:0]  o_wb_ctrl,
    output logic [MEM_CW-1:0] o_mem_ctrl
);

    logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res, ex_res, mdu_hi, mdu_lo;
    logic [4:0]        shamt;
    logic              is_mdu, mdu_busy, mdu_last, start, abort, stall_raw, bubble;

    logic              valid_q, zero_q;
    logic [DATA_W-1:0] branch_pc_q, result_q, rt_data_q;
    logic [REG_AW-1:0] write_reg_q;
    logic [WB_CW-1:0]  wb_ctrl_q;
    logic [MEM_CW-1:0] mem_ctrl_q;

    always_comb begin
        case (i_fwd_a)
            FWD_WB:  fwd_a = i_wb_data;
            FWD_MEM: fwd_a = i_mem_data;
            default: fwd_a = i_rs_data;
        endcase
        case (i_fwd_b)
            FWD_WB:  fwd_b = i_wb_data;
            FWD_MEM: fwd_b = i_mem_data;
            default: fwd_b = i_rt_data;
        endcase
    end

    assign alu_b = i_alu_src ? i_imm : fwd_b;
    assign shamt = i_imm[10:6];

    always_comb begin
        alu_res = '0;
        case (i_alu_op)
            ALU_AND:  alu_res = fwd_a & alu_b;
            ALU_OR:   alu_res = fwd_a | alu_b;
            ALU_ADD:  alu_res = fwd_a + alu_b;
            ALU_SUB:  alu_res = fwd_a - alu_b;
            ALU_SLT:  alu_res = DATA_W'($signed(fwd_a) < $signed(alu_b));
            ALU_SLTU: alu_res = DATA_W'(fwd_a < alu_b);
            ALU_NOR:  alu_res = ~(fwd_a | alu_b);
            ALU_SLL:  alu_res = alu_b << shamt;
            ALU_SRL:  alu_res = alu_b >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> shamt);
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        case (i_mdu_op)
            MDU_MFHI: ex_res = mdu_hi;
            MDU_MFLO: ex_res = mdu_lo;
            default:  ex_res = alu_res;
        endcase
    end

`ifdef EX_STAGE_DIV_EN
    assign is_mdu = i_mdu_op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
`else
    assign is_mdu = i_mdu_op inside {MDU_MULT, MDU_MULTU};
`endif

    assign start     = !mdu_busy && i_valid && is_mdu && !i_flush && !i_mem_stall;
    assign abort     = mdu_busy && i_flush && !i_mem_stall;
    assign stall_raw = i_mem_stall || start || (mdu_busy && !mdu_last);
    assign o_stall   = i_rst_n && stall_raw;
    assign bubble    = i_flush || stall_raw || !i_valid;

    ex_mdu #(
        .DATA_W (DATA_W)
    ) u_mdu (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .start     (start),
        .abort     (abort),
        .freeze    (i_mem_stall),
        .op        (i_mdu_op),
        .op_a      (fwd_a),
        .op_b      (fwd_b),
        .busy      (mdu_busy),
        .busy_last (mdu_last),
        .hi        (mdu_hi),
        .lo        (mdu_lo)
    );

    // Bubble data fields are don't-care; they are loaded anyway to keep the mux small.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q     <= 1'b0;
            zero_q      <= 1'b0;
            branch_pc_q <= '0;
            result_q    <= '0;
            rt_data_q   <= '0;
            write_reg_q <= '0;
            wb_ctrl_q   <= '0;
            mem_ctrl_q  <= '0;
        end else if (!i_mem_stall) begin
            valid_q     <= !bubble;
            zero_q      <= (alu_res == '0);
            branch_pc_q <= i_next_pc + (i_imm << 2);
            result_q    <= ex_res;
            rt_data_q   <= fwd_b;
            write_reg_q <= i_reg_dst ? i_des_reg : i_tar_reg;
            wb_ctrl_q   <= bubble ? {WB_CW{BUBBLE_CTRL}} : i_wb_ctrl;
            mem_ctrl_q  <= bubble ? {MEM_CW{BUBBLE_CTRL}} : i_mem_ctrl;
        end
    end

    assign o_valid     = valid_q;
    assign o_zero      = zero_q;
    assign o_branch_pc = branch_pc_q;
    assign o_result    = result_q;
    assign o_rt_data   = rt_data_q;
    assign o_write_reg = write_reg_q;
    assign o_wb_ctrl   = wb_ctrl_q;
    assign o_mem_ctrl  = mem_ctrl_q;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu; DIV expectations follow EX_STAGE_DIV_EN.
module tb_ex_stage_mdu;
    import ex_pkg::*;

    logic        i_clk, i_rst_n, i_valid;
    logic [31:0] i_next_pc, i_rs_data, i_rt_data, i_imm, i_wb_data, i_mem_data;
    logic [4:0]  i_tar_reg, i_des_reg;
    logic [1:0]  i_wb_ctrl, i_fwd_a, i_fwd_b;
    logic [2:0]  i_mem_ctrl, i_mdu_op;
    logic        i_alu_src, i_reg_dst, i_flush, i_mem_stall;
    logic [3:0]  i_alu_op;
    logic        o_stall, o_valid, o_zero;
    logic [31:0] o_branch_pc, o_result, o_rt_data;
    logic [4:0]  o_write_reg;
    logic [1:0]  o_wb_ctrl;
    logic [2:0]  o_mem_ctrl;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    ex_stage_mdu dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_next_pc   (i_next_pc),
        .i_rs_data   (i_rs_data),
        .i_rt_data   (i_rt_data),
        .i_imm       (i_imm),
        .i_tar_reg   (i_tar_reg),
        .i_des_reg   (i_des_reg),
        .i_wb_ctrl   (i_wb_ctrl),
        .i_mem_ctrl  (i_mem_ctrl),
        .i_alu_src   (i_alu_src),
        .i_reg_dst   (i_reg_dst),
        .i_alu_op    (i_alu_op),
        .i_mdu_op    (i_mdu_op),
        .i_fwd_a     (i_fwd_a),
        .i_fwd_b     (i_fwd_b),
        .i_wb_data   (i_wb_data),
        .i_mem_data  (i_mem_data),
        .i_flush     (i_flush),
        .i_mem_stall (i_mem_stall),
        .o_stall     (o_stall),
        .o_valid     (o_valid),
        .o_zero      (o_zero),
        .o_branch_pc (o_branch_pc),
        .o_result    (o_result),
        .o_rt_data   (o_rt_data),
        .o_write_reg (o_write_reg),
        .o_wb_ctrl   (o_wb_ctrl),
        .o_mem_ctrl  (o_mem_ctrl)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] aop, input logic [2:0] mop,
                         input logic [31:0] a, input logic [31:0] b);
        i_valid   = 1'b1;
        i_alu_op  = aop;
        i_mdu_op  = mop;
        i_rs_data = a;
        i_rt_data = b;
        i_fwd_a   = FWD_REG;
        i_fwd_b   = FWD_REG;
        i_alu_src = 1'b0;
        i_flush   = 1'b0;
    endtask

    // Issue an MDU op, count stalled cycles, then let it retire into EX/MEM.
    task automatic run_mdu(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                           output int cnt);
        drive(ALU_ADD, mop, a, b);
        #1;
        cnt = 0;
        while (o_stall && cnt < 100) begin
            cnt++;
            step();
        end
        step();
        i_valid  = 1'b0;
        i_mdu_op = MDU_NONE;
    endtask

    task automatic mf(input string tag, input logic [2:0] mop, input logic [31:0] exp);
        drive(ALU_ADD, mop, 32'd0, 32'd0);
        #1;
        chk({tag, "_nostall"}, o_stall, 0);
        step();
        chk(tag, o_result, exp);
        i_valid  = 1'b0;
        i_mdu_op = MDU_NONE;
    endtask

    initial begin
        i_rst_n = 0; i_valid = 0; i_next_pc = 0; i_rs_data = 0; i_rt_data = 0; i_imm = 0;
        i_tar_reg = 0; i_des_reg = 0; i_wb_ctrl = 0; i_mem_ctrl = 0; i_alu_src = 0;
        i_reg_dst = 0; i_alu_op = 0; i_mdu_op = 0; i_fwd_a = 0; i_fwd_b = 0;
        i_wb_data = 0; i_mem_data = 0; i_flush = 0; i_mem_stall = 1;
        #2;
        chk("rst_stall", o_stall, 0);
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_wb_ctrl", o_wb_ctrl, 0);
        @(negedge i_clk);
        i_rst_n = 1; i_mem_stall = 0;
        step();

        // Forwarded ADD
        drive(ALU_ADD, MDU_NONE, 32'd5, 32'd100);
        i_fwd_b = FWD_WB; i_wb_data = 32'd7; i_wb_ctrl = 2'b11; i_mem_ctrl = 3'b101;
        i_tar_reg = 5'd3; i_des_reg = 5'd9;
        step();
        chk("add_fwd_wb", o_result, 32'd12);
        chk("add_zero", o_zero, 0);
        chk("add_valid", o_valid, 1);
        chk("add_write_reg", o_write_reg, 5'd3);
        chk("add_wb_ctrl", o_wb_ctrl, 2'b11);
        chk("add_mem_ctrl", o_mem_ctrl, 3'b101);
        chk("add_rt_data", o_rt_data, 32'd7);
        i_fwd_b = FWD_REG_ALT;
        step();
        chk("add_fwd11", o_result, 32'd105);
        chk("rt_fwd11", o_rt_data, 32'd100);
        drive(ALU_SUB, MDU_NONE, 32'd0, 32'd100);
        i_fwd_a = FWD_MEM; i_mem_data = 32'd20;
        step();
        chk("sub_fwd_mem", o_result, 32'hFFFF_FFB0);

        // SUB to zero, rd select, branch target
        drive(ALU_SUB, MDU_NONE, 32'd9, 32'd9);
        i_reg_dst = 1; i_des_reg = 5'd17; i_next_pc = 32'h100; i_imm = 32'hFFFF_FFFF;
        step();
        chk("sub_result", o_result, 0);
        chk("sub_zero", o_zero, 1);
        chk("sub_write_reg", o_write_reg, 5'd17);
        chk("branch_pc", o_branch_pc, 32'hFC);

        drive(ALU_SLT, MDU_NONE, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("slt", o_result, 1);
        drive(ALU_SLTU, MDU_NONE, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("sltu", o_result, 0);
        drive(ALU_SRA, MDU_NONE, 32'd0, 32'h8000_0000);
        i_imm = 32'h100;
        step();
        chk("sra", o_result, 32'hF800_0000);
        drive(ALU_SRL, MDU_NONE, 32'd0, 32'h8000_0000);
        step();
        chk("srl", o_result, 32'h0800_0000);
        drive(ALU_SLL, MDU_NONE, 32'd0, 32'h1);
        step();
        chk("sll", o_result, 32'h10);
        drive(ALU_OR, MDU_NONE, 32'hF0, 32'h1234);
        i_alu_src = 1; i_imm = 32'h0F;
        step();
        chk("or_imm", o_result, 32'hFF);
        drive(ALU_NOR, MDU_NONE, 32'h0, 32'h0);
        step();
        chk("nor", o_result, 32'hFFFF_FFFF);
        drive(ALU_AND, MDU_NONE, 32'hF0F0, 32'h0FF0);
        step();
        chk("and", o_result, 32'h00F0);
        drive(4'b1111, MDU_NONE, 32'd5, 32'd5);
        step();
        chk("undef_op", o_result, 0);
        chk("undef_zero", o_zero, 1);

        // Flush and downstream hold
        drive(ALU_ADD, MDU_NONE, 32'd1, 32'd1);
        i_flush = 1;
        step();
        chk("flush_valid", o_valid, 0);
        chk("flush_wb", o_wb_ctrl, 0);
        chk("flush_mem", o_mem_ctrl, 0);
        drive(ALU_ADD, MDU_NONE, 32'd2, 32'd3);
        i_wb_ctrl = 2'b10;
        step();
        chk("pre_hold", o_result, 32'd5);
        drive(ALU_ADD, MDU_NONE, 32'd10, 32'd10);
        i_mem_stall = 1;
        #1;
        chk("hold_stall", o_stall, 1);
        step();
        chk("hold_result", o_result, 32'd5);
        chk("hold_valid", o_valid, 1);
        chk("hold_wb", o_wb_ctrl, 2'b10);
        i_mem_stall = 0;
        i_valid = 0;
        step();

        // Multiply
        run_mdu(MDU_MULT, 32'hFFFF_FFFD, 32'd4, n);
        chk("mult_stall_cycles", n, 32);
        mf("mult_lo", MDU_MFLO, 32'hFFFF_FFF4);
        mf("mult_hi", MDU_MFHI, 32'hFFFF_FFFF);
        run_mdu(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, n);
        chk("multu_stall_cycles", n, 32);
        mf("multu_lo", MDU_MFLO, 32'hFFFF_FFFE);
        mf("multu_hi", MDU_MFHI, 32'd1);

        // Divide
`ifdef EX_STAGE_DIV_EN
        run_mdu(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_stall_cycles", n, 32);
        mf("div_lo", MDU_MFLO, 32'hFFFF_FFFD);
        mf("div_hi", MDU_MFHI, 32'hFFFF_FFFF);
        run_mdu(MDU_DIVU, 32'd7, 32'd0, n);
        chk("divu0_stall_cycles", n, 32);
        mf("divu0_lo", MDU_MFLO, 32'hFFFF_FFFF);
        mf("divu0_hi", MDU_MFHI, 32'd7);
`else
        run_mdu(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_off_stall", n, 0);
        mf("div_off_lo", MDU_MFLO, 32'hFFFF_FFFE);
        mf("div_off_hi", MDU_MFHI, 32'd1);
`endif

        // Abort mid-multiply
        run_mdu(MDU_MULTU, 32'd3, 32'd5, n);
        chk("pre_abort_cycles", n, 32);
        drive(ALU_ADD, MDU_MULT, 32'd7, 32'd7);
        step();
        repeat (10) step();
        i_flush = 1;
        #1;
        chk("abort_stall_before", o_stall, 1);
        step();
        i_flush = 0; i_valid = 0; i_mdu_op = MDU_NONE;
        #1;
        chk("abort_stall_after", o_stall, 0);
        chk("abort_valid", o_valid, 0);
        chk("abort_wb", o_wb_ctrl, 0);
        chk("abort_mem", o_mem_ctrl, 0);
        step();
        mf("abort_lo", MDU_MFLO, 32'd15);
        mf("abort_hi", MDU_MFHI, 32'd0);

        // Downstream stall in the middle of a multiply
        drive(ALU_ADD, MDU_MULTU, 32'd6, 32'd7);
        n = 0;
        repeat (5) begin
            #1;
            if (o_stall) n++;
            step();
        end
        i_mem_stall = 1;
        repeat (3) begin
            #1;
            if (o_stall) n++;
            step();
        end
        i_mem_stall = 0;
        #1;
        while (o_stall && n < 100) begin
            n++;
            step();
        end
        chk("memstall_cycles", n, 35);
        step();
        i_valid = 0; i_mdu_op = MDU_NONE;
        mf("memstall_lo", MDU_MFLO, 32'd42);

        // Reset in the middle of an operation
`ifdef EX_STAGE_DIV_EN
        drive(ALU_ADD, MDU_DIVU, 32'd100, 32'd7);
`else
        drive(ALU_ADD, MDU_MULTU, 32'd100, 32'd7);
`endif
        repeat (5) step();
        i_rst_n = 0;
        #1;
        chk("midrst_stall", o_stall, 0);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_result", o_result, 0);
        chk("midrst_branch", o_branch_pc, 0);
        @(negedge i_clk);
        i_rst_n = 1; i_valid = 0; i_mdu_op = MDU_NONE;
        step();
        mf("midrst_lo", MDU_MFLO, 32'd0);
        mf("midrst_hi", MDU_MFHI, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
